// File: rtl/puf_challenge_sequencer_pkg.sv
// puf_pkg: shared state encoding and default sizing for the challenge sequencer
package puf_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_HOLD, ST_ERROR} puf_seq_state_t;
  localparam int PUF_N_CHAL = 8;
  localparam int PUF_CHAL_W = 3;
  localparam int PUF_RESP_W = 2;
  localparam int PUF_KEY_W = PUF_N_CHAL * PUF_RESP_W;
endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// puf_seq_if: key-consumer handshake plus RO datapath control bundle
interface puf_seq_if
  import puf_pkg::*;
#(
  parameter int N_CHAL = PUF_N_CHAL,
  parameter int CHAL_W = PUF_CHAL_W,
  parameter int RESP_W = PUF_RESP_W
) ();
  logic req, busy, key_valid, key_ready, err, ro_start, meas_done;
  logic [N_CHAL*RESP_W-1:0] key;
  logic [CHAL_W-1:0] challenge;
  logic [RESP_W-1:0] meas_resp;
  modport master (
    input req, key_ready, meas_done, meas_resp,
    output busy, key, key_valid, err, challenge, ro_start
  );
  modport slave (
    output req, key_ready, meas_done, meas_resp,
    input busy, key, key_valid, err, challenge, ro_start
  );
endinterface

// File: rtl/puf_challenge_sequencer_timer.sv
// puf_cycle_timer: loadable down-counter that parks at zero
module puf_cycle_timer #(
  parameter int W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic zero
);
  assign zero = value == '0;
  // load wins; otherwise count down and stop at zero
  always_ff @(posedge clk)
    if (!rst_n) value <= '0;
    else value <= load ? load_val : zero ? value : value - 1'b1;
endmodule

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer: sweeps every PUF challenge and packs the responses into a key
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int N_CHAL = PUF_N_CHAL,
  parameter int CHAL_W = PUF_CHAL_W,
  parameter int RESP_W = PUF_RESP_W,
  parameter int SETTLE = 4,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic rst_n,
  puf_seq_if.master bus
);
  localparam int KEY_W = N_CHAL * RESP_W;
  localparam int TMAX = SETTLE > TIMEOUT ? SETTLE : TIMEOUT;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  puf_seq_state_t state;
  logic [KEY_W-1:0] key;
  logic [CHAL_W-1:0] challenge;
  logic err, tload, tzero, last;
  logic [TW-1:0] tval, tvalue;
  assign last = challenge == CHAL_W'(N_CHAL - 1);
  assign tload = (state == ST_IDLE && bus.req) || (state == ST_SETTLE && tzero) ||
                 (state == ST_MEASURE && bus.meas_done && !last);
  assign tval = state == ST_SETTLE ? TW'(TIMEOUT - 1) : TW'(SETTLE - 1);
  puf_cycle_timer #(.W(TW)) timer (
    .clk(clk), .rst_n(rst_n), .load(tload), .load_val(tval), .value(tvalue), .zero(tzero)
  );
  assign bus.busy = state != ST_IDLE;
  assign bus.key_valid = state == ST_HOLD;
  assign bus.ro_start = state == ST_MEASURE;
  assign bus.key = key;
  assign bus.challenge = challenge;
  assign bus.err = err;
  // sweep FSM: settle, measure, capture slot, advance; done beats the timeout
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ST_IDLE;
      key <= '0;
      challenge <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req) begin
          state <= ST_SETTLE;
          challenge <= '0;
          err <= 1'b0;
          key <= '0;
        end
        ST_SETTLE: if (tzero) state <= ST_MEASURE;
        ST_MEASURE: if (bus.meas_done) begin
          key[challenge*RESP_W +: RESP_W] <= bus.meas_resp;
          if (last) state <= ST_HOLD;
          else begin
            challenge <= challenge + CHAL_W'(1);
            state <= ST_SETTLE;
          end
        end else if (tzero) begin
          state <= ST_ERROR;
          err <= 1'b1;
        end
        ST_HOLD: if (bus.key_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Controller that turns the single-challenge ring-oscillator PUF datapath into a full key generator. On request it steps the 3-bit challenge through every value and, for each one, gates the RO enable / counter start and waits for the counter's done. It then packs each 2-bit response into a 16-bit key returned over a valid/ready handshake. It sits between the key consumer (e.g. key-derivation logic) and the RO arrays, mux pair, counter unit and comparator.

## Interface

Parameters:
- N_CHAL, 8, number of challenges swept; challenge values 0..N_CHAL-1
- CHAL_W, 3, challenge width; N_CHAL <= 2**CHAL_W
- RESP_W, 2, response bits per challenge
- SETTLE, 4, cycles ro_start is held low before each measurement (clears counter, quiets ROs); >= 1
- TIMEOUT, 1024, max cycles in MEASURE without meas_done before abort; >= 2

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  1  start key generation; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- key  out  N_CHAL*RESP_W  assembled key; bits [RESP_W*i +: RESP_W] = response for challenge i
- key_valid  out  1  key stable and complete
- key_ready  in  1  consumer accepts key
- err  out  1  sticky timeout flag; cleared on next accepted req
- challenge  out  CHAL_W  challenge to both RO muxes
- ro_start  out  1  enable to RO arrays and counter start
- meas_done  in  1  counter window complete
- meas_resp  in  RESP_W  comparator response, valid when meas_done=1

## Operation

- States: IDLE, SETTLE, MEASURE, HOLD, ERROR.
- IDLE: req=1 -> SETTLE, challenge<=0, err<=0, key<=0, timer<=SETTLE-1.
- SETTLE: ro_start=0. Timer counts down; at 0 -> MEASURE, timer<=TIMEOUT-1.
- MEASURE: ro_start=1, challenge held.
  - meas_done=1 -> key slot[challenge]<=meas_resp.
    - challenge==N_CHAL-1 -> HOLD.
    - Else challenge+1 -> SETTLE, timer<=SETTLE-1.
  - meas_done=0 with timer==0 -> ERROR, err<=1.
  - meas_done=1 on the timer==0 cycle counts as success; done has priority.
- HOLD: key_valid=1, key frozen. key_ready=1 -> IDLE; key_valid drops the next cycle and key keeps its value.
- ERROR: err=1, key_valid=0, ro_start=0. Always -> IDLE on the next cycle; err stays high until a new req is accepted.
- req is ignored outside IDLE. meas_done is ignored outside MEASURE.
- challenge never exceeds N_CHAL-1. No wrap: sweep always ends in HOLD or ERROR.

## Timing

- Reset (rst_n=0 at an edge): state=IDLE, busy=0, key=0, key_valid=0, err=0, challenge=0, ro_start=0, timer=0. This holds mid-sweep too; a partial key is discarded.
- All outputs are registered; none depend combinationally on inputs.
- req edge -> ro_start low for exactly SETTLE cycles -> ro_start high from cycle SETTLE+1 after the req edge.
- Per challenge: SETTLE cycles low + D cycles high, where D = number of MEASURE cycles up to and including the one with meas_done=1.
- Response capture happens on the meas_done edge. ro_start is low in the following cycle.
- Total req -> key_valid latency = N_CHAL*(SETTLE+D) cycles (D constant).
- Back-to-back: key_ready in HOLD -> IDLE. The earliest new req is accepted on the next edge, so there is a 1-cycle IDLE gap.
- Timeout: ERROR is entered TIMEOUT cycles after MEASURE entry if no done.

## Structure

- Package puf_pkg holds:
  - State enum puf_seq_state_t (IDLE, SETTLE, MEASURE, HOLD, ERROR).
  - Default constants PUF_N_CHAL=8, PUF_CHAL_W=3, PUF_RESP_W=2.
  - Key width PUF_KEY_W = PUF_N_CHAL*PUF_RESP_W.
- One sub-module, puf_cycle_timer: loadable down-counter (load, value, zero flag), width $clog2(max(SETTLE,TIMEOUT)). It is shared by SETTLE and MEASURE.
- Everything else (FSM, challenge counter, key shift/slot write) is in the top of this block.

## Test plan

- Nominal sweep: bench model asserts done 10 cycles into MEASURE with resp = challenge[1:0]. Send req, hold key_ready=1 → key=16'hE4E4, key_valid after 8*(4+10)=112 cycles, err=0, challenge visits 0..7 in order.
- Backpressure: same stimulus, key_ready=0 for 20 cycles in HOLD → key_valid and key stable 20 cycles, IDLE one cycle after ready.
- Timeout: model never asserts done for challenge 5 → ERROR after 1024 MEASURE cycles, err=1, key_valid never high, ro_start=0. Next req clears err and completes normally.
- Reset mid-sweep: rst_n=0 for 1 cycle while challenge=3 in MEASURE → all outputs zero next cycle. A late meas_done pulse is ignored and no capture occurs.
- Ignored inputs: req pulsed during SETTLE/MEASURE/HOLD, meas_done pulsed during SETTLE → no state or key change. Done on the final timeout cycle → success, no err.
